// File: rtl/dcm_lock_sequencer.sv
// Brings up two cascaded DCMs: resets each in turn, waits for lock, qualifies stability, retries on failure.
// Optional macro DCM_STATUS_MON_EN treats CLKIN/CLKFX-stopped STATUS bits as a lock drop in STABLE/READY.
module dcm_lock_sequencer #(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned LOCK_TIMEOUT  = 65535,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned STABLE_CYCLES = 255
) (
   input  logic        BUS_CLK,
   input  logic        BUS_RST_N,
   input  logic        USER_RST,
   input  logic        U1_LOCKED,
   input  logic [7:0]  U1_STATUS,
   input  logic        U2_LOCKED,
   input  logic [7:0]  U2_STATUS,
   output logic        U1_RST,
   output logic        U2_RST,
   output logic        CLK_READY,
   output logic        FAIL,
   output logic [7:0]  RETRY_CNT,
   output logic [15:0] LOSS_CNT
);

   typedef enum logic [2:0] {
      S_RST1, S_WAIT1, S_RST2, S_WAIT2, S_STABLE, S_READY, S_FAIL
   } state_t;

   localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STB_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

   state_t      r_state;
   logic [15:0] r_timer;
   logic [1:0]  r_u1_sync, r_u2_sync;
   logic        r_u1_rst, r_u2_rst, r_ready, r_fail;
   logic [7:0]  r_retry;
   logic [15:0] r_loss;

   state_t      w_nxt;
   logic        w_retry, w_loss, w_clk_stop, w_locks_ok;
   logic        w_u1_lk, w_u2_lk;
   logic [7:0]  w_retry_inc;
   logic        w_unused_status;

   // Only STATUS[2:1] can ever matter; the rest is left unconnected on purpose.
   assign w_unused_status = ^{U1_STATUS, U2_STATUS};

   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         r_u1_sync <= '0;
         r_u2_sync <= '0;
      end else begin
         r_u1_sync <= {r_u1_sync[0], U1_LOCKED};
         r_u2_sync <= {r_u2_sync[0], U2_LOCKED};
      end
   end

`ifdef DCM_STATUS_MON_EN
   logic [3:0] r_st_meta, r_st_sync;
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         r_st_meta <= '0;
         r_st_sync <= '0;
      end else begin
         r_st_meta <= {U2_STATUS[2:1], U1_STATUS[2:1]};
         r_st_sync <= r_st_meta;
      end
   end
   assign w_clk_stop = |r_st_sync;
`else
   assign w_clk_stop = 1'b0;
`endif

   assign w_u1_lk     = r_u1_sync[1];
   assign w_u2_lk     = r_u2_sync[1];
   assign w_locks_ok  = w_u1_lk & w_u2_lk & ~w_clk_stop;
   assign w_retry_inc = (r_retry == 8'hFF) ? 8'hFF : r_retry + 8'd1;

   // Lock is tested before the timeout so a same-cycle lock always wins.
   always_comb begin
      w_nxt   = r_state;
      w_retry = 1'b0;
      w_loss  = 1'b0;
      if (USER_RST) begin
         w_nxt = S_RST1;
      end else begin
         case (r_state)
            S_RST1:   if (r_timer == RST_LAST) w_nxt = S_WAIT1;
            S_WAIT1:  if (w_u1_lk) w_nxt = S_RST2;
                      else if (r_timer == TO_LAST) w_retry = 1'b1;
            S_RST2:   if (r_timer == RST_LAST) w_nxt = S_WAIT2;
            S_WAIT2:  if (!w_u1_lk) w_retry = 1'b1;
                      else if (w_u2_lk) w_nxt = S_STABLE;
                      else if (r_timer == TO_LAST) w_retry = 1'b1;
            S_STABLE: if (!w_locks_ok) w_retry = 1'b1;
                      else if (r_timer == STB_LAST) w_nxt = S_READY;
            S_READY:  if (!w_locks_ok) begin
                         w_loss = 1'b1;
                         w_nxt  = S_RST1;
                      end
            default:  w_nxt = r_state;
         endcase
         if (w_retry) w_nxt = (w_retry_inc == RETRY_MAX) ? S_FAIL : S_RST1;
      end
   end

   // Outputs are registered from the next state so they switch on the same edge as the state.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         r_state  <= S_RST1;
         r_timer  <= '0;
         r_u1_rst <= 1'b1;
         r_u2_rst <= 1'b1;
         r_ready  <= 1'b0;
         r_fail   <= 1'b0;
         r_retry  <= '0;
         r_loss   <= '0;
      end else begin
         r_state  <= w_nxt;
         if (USER_RST || (w_nxt != r_state)) r_timer <= '0;
         else if (r_timer != 16'hFFFF)       r_timer <= r_timer + 16'd1;
         r_u1_rst <= (w_nxt == S_RST1) || (w_nxt == S_FAIL);
         r_u2_rst <= (w_nxt == S_RST1) || (w_nxt == S_WAIT1) ||
                     (w_nxt == S_RST2) || (w_nxt == S_FAIL);
         r_ready  <= (w_nxt == S_READY);
         r_fail   <= (w_nxt == S_FAIL);
         if (USER_RST || w_loss) r_retry <= '0;
         else if (w_retry)       r_retry <= w_retry_inc;
         if (w_loss && (r_loss != 16'hFFFF)) r_loss <= r_loss + 16'd1;
      end
   end

   assign U1_RST    = r_u1_rst;
   assign U2_RST    = r_u2_rst;
   assign CLK_READY = r_ready;
   assign FAIL      = r_fail;
   assign RETRY_CNT = r_retry;
   assign LOSS_CNT  = r_loss;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Bench for dcm_lock_sequencer: behavioural DCM lock model, vector table of lock delays, scoreboard of outcomes.
module tb_dcm_lock_sequencer;

   localparam int RST_CYCLES    = 8;
   localparam int LOCK_TIMEOUT  = 100;
   localparam int MAX_RETRY     = 3;
   localparam int STABLE_CYCLES = 16;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST_N = 1'b0;
   logic        USER_RST = 1'b0;
   logic        U1_LOCKED = 1'b0, U2_LOCKED = 1'b0;
   logic [7:0]  U1_STATUS = 8'h00, U2_STATUS = 8'h00;
   logic        U1_RST, U2_RST, CLK_READY, FAIL;
   logic [7:0]  RETRY_CNT;
   logic [15:0] LOSS_CNT;

   dcm_lock_sequencer #(
      .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .MAX_RETRY(MAX_RETRY), .STABLE_CYCLES(STABLE_CYCLES)
   ) dut (
      .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .USER_RST(USER_RST),
      .U1_LOCKED(U1_LOCKED), .U1_STATUS(U1_STATUS),
      .U2_LOCKED(U2_LOCKED), .U2_STATUS(U2_STATUS),
      .U1_RST(U1_RST), .U2_RST(U2_RST), .CLK_READY(CLK_READY), .FAIL(FAIL),
      .RETRY_CNT(RETRY_CNT), .LOSS_CNT(LOSS_CNT)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   typedef struct { int u1; int u2; logic fail; logic [7:0] retry; } vec_t;
   typedef struct { logic fail; logic [7:0] retry; logic [15:0] loss; } exp_t;

   vec_t vt[7];
   exp_t sbq[$];
   int   n_chk = 0, n_fail = 0;
   int   u1_dly = 20, u2_dly = 30, u1_cnt = 0, u2_cnt = 0, u2_drop = 0;
   logic [15:0] loss_exp = 16'd0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endtask

   // One cycle: sample at the falling edge, then update the DCM model (lock N ticks after its reset falls).
   task automatic tick();
      @(negedge BUS_CLK);
      if (U1_RST) u1_cnt = 0; else if (u1_cnt < 5000) u1_cnt++;
      if (U2_RST) u2_cnt = 0; else if (u2_cnt < 5000) u2_cnt++;
      U1_LOCKED = !U1_RST && (u1_cnt >= u1_dly);
      U2_LOCKED = !U2_RST && (u2_cnt >= u2_dly) && (u2_drop == 0);
      if (u2_drop > 0) u2_drop--;
   endtask

   task automatic user_rst_pulse();
      USER_RST = 1'b1;
      tick();
      USER_RST = 1'b0;
      check("user_rst_fail_clr", FAIL, 0);
      check("user_rst_retry_clr", RETRY_CNT, 0);
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!(CLK_READY || FAIL) && n < 3000) begin
         tick();
         n++;
      end
      check(nm, CLK_READY || FAIL, 1);
   endtask

   task automatic wait_u1rst(input logic lvl, input string nm);
      int n = 0;
      while (U1_RST !== lvl && n < 300) begin
         tick();
         n++;
      end
      check(nm, U1_RST, lvl);
   endtask

   task automatic sb_compare(input string nm);
      exp_t e;
      if (sbq.size() == 0) begin
         check({nm, "_sb_empty"}, 0, 1);
         return;
      end
      e = sbq.pop_front();
      check({nm, "_fail"}, FAIL, e.fail);
      check({nm, "_ready"}, CLK_READY, !e.fail);
      check({nm, "_retry"}, RETRY_CNT, e.retry);
      check({nm, "_loss"}, LOSS_CNT, e.loss);
      if (e.fail) check({nm, "_rsts"}, {U1_RST, U2_RST}, 2'b11);
   endtask

   initial begin
      int n, hold, t_u2, lowc;
      bit saw_ready;

      vt[0] = '{20, 30, 1'b0, 8'd0};
      vt[1] = '{1,  1,  1'b0, 8'd0};
      vt[2] = '{98, 5,  1'b0, 8'd0};   // lock lands in the same cycle as the WAIT1 timeout
      vt[3] = '{99, 5,  1'b1, 8'd3};   // one cycle too late: every attempt times out
      vt[4] = '{5,  98, 1'b0, 8'd0};   // same tie in WAIT2
      vt[5] = '{5,  99, 1'b1, 8'd3};
      vt[6] = '{4000, 5, 1'b1, 8'd3};

      // Reset state
      repeat (3) tick();
      check("rst_u1_rst", U1_RST, 1);
      check("rst_u2_rst", U2_RST, 1);
      check("rst_ready", CLK_READY, 0);
      check("rst_fail", FAIL, 0);
      check("rst_retry", RETRY_CNT, 0);
      check("rst_loss", LOSS_CNT, 0);

      // Nominal start: first RST1 pulse is full length after release
      BUS_RST_N = 1'b1;
      n = 0;
      do begin tick(); n++; end while (U1_RST && n < 50);
      check("rst1_first_len", n, RST_CYCLES);
      hold = (!U1_RST && U2_RST) ? 1 : 0;
      n = 0; t_u2 = -1;
      while (!(CLK_READY || FAIL) && n < 3000) begin
         tick();
         n++;
         if (!U1_RST && U2_RST) hold++;
         if (U2_LOCKED && t_u2 < 0) t_u2 = n;
      end
      // WAIT1 = lock delay + 2 sync cycles, then RST2 for RST_CYCLES
      check("u2_rst_hold", hold, 20 + 2 + RST_CYCLES);
      // 2 sync cycles, WAIT2->STABLE transition, STABLE_CYCLES qualification
      check("ready_latency", n - t_u2, STABLE_CYCLES + 3);
      check("nominal_ready", CLK_READY, 1);
      check("nominal_retry", RETRY_CNT, 0);

      // Vector table, outcome scoreboarded
      foreach (vt[i]) begin
         u1_dly = vt[i].u1;
         u2_dly = vt[i].u2;
         user_rst_pulse();
         sbq.push_back('{vt[i].fail, vt[i].retry, loss_exp});
         wait_done($sformatf("vec%0d_done", i));
         sb_compare($sformatf("vec%0d", i));
      end

      // U1 never locks: three 100-cycle WAIT1 windows
      u1_dly = 4000; u2_dly = 30;
      user_rst_pulse();
      for (int a = 0; a < MAX_RETRY; a++) begin
         wait_u1rst(1'b0, "to_u1_fall");
         lowc = 0;
         while (!U1_RST && lowc < 300) begin tick(); lowc++; end
         check($sformatf("to_wait1_len%0d", a), lowc, LOCK_TIMEOUT);
         check($sformatf("to_retry%0d", a), RETRY_CNT, a + 1);
      end
      check("to_fail", FAIL, 1);
      repeat (20) tick();
      check("to_fail_held", {FAIL, U1_RST, U2_RST, CLK_READY}, 4'b1110);

      // Recover from FAIL with USER_RST
      u1_dly = 20;
      user_rst_pulse();
      sbq.push_back('{1'b0, 8'd0, loss_exp});
      wait_done("recover_done");
      sb_compare("recover");

      // Lock drop mid-STABLE
      user_rst_pulse();
      n = 0;
      while (!U2_LOCKED && n < 300) begin tick(); n++; end
      check("stb_u2_lock", U2_LOCKED, 1);
      repeat (10) tick();
      u2_drop = 1;
      saw_ready = 0;
      n = 0;
      while (!U1_RST && n < 30) begin
         tick();
         n++;
         if (CLK_READY) saw_ready = 1;
      end
      check("stb_restart", U1_RST, 1);
      check("stb_no_ready", saw_ready, 0);
      check("stb_retry", RETRY_CNT, 1);
      sbq.push_back('{1'b0, 8'd1, loss_exp});
      wait_done("stb_done");
      sb_compare("stb");

      // One-cycle loss in READY
      u2_drop = 1;
      tick();
      wait_u1rst(1'b1, "loss_restart");
      loss_exp++;
      check("loss_ready", CLK_READY, 0);
      check("loss_cnt", LOSS_CNT, loss_exp);
      check("loss_retry_clr", RETRY_CNT, 0);
      n = 0;
      while (U1_RST && n < 50) begin tick(); n++; end
      check("loss_rst1_len", n, RST_CYCLES);
      sbq.push_back('{1'b0, 8'd0, loss_exp});
      wait_done("loss_done");
      sb_compare("loss");

      // CLKIN-stopped status in READY
      U1_STATUS = 8'h02;
      tick();
      U1_STATUS = 8'h00;
      repeat (10) tick();
`ifdef DCM_STATUS_MON_EN
      loss_exp++;
      check("status_loss", LOSS_CNT, loss_exp);
      check("status_restart", CLK_READY, 0);
`else
      check("status_loss", LOSS_CNT, loss_exp);
      check("status_ignored", CLK_READY, 1);
`endif
      sbq.push_back('{1'b0, 8'd0, loss_exp});
      wait_done("status_done");
      sb_compare("status");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
